// File: rtl/spi_dbg_pkg.sv
// Shared definitions for the SPI debug bridge.
//   state_t    : bridge FSM encoding (IDLE, CMD, WRITE, READ)
//   cmd_rd_bit : bit position of the read flag inside a command word (DW-1)
package spi_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  function automatic int cmd_rd_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   i_clk : destination clock
//   i_rst : synchronous active-high reset (clears both flops)
//   i_d   : asynchronous input
//   o_q   : synchronized output
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta, r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_debug_bridge.sv
// SPI (mode 0, LSB-first) to parallel register-bus debug bridge.
// First word of a frame is a command (bit DW-1 = read, bits AW-1:0 = start
// address); following words are written to / read from consecutive addresses.
// Optional read path is built only when SPI_DEBUG_READ_EN is defined;
// otherwise read frames are silently sunk.
// Ports:
//   sys_clk, sys_rst            : system clock, sync active-high reset
//   spi_clk, spi_cs_i, spi_data_i : async SPI inputs (sclk, cs_n, MOSI)
//   spi_data_o                  : MISO
//   sys_wr_o, sys_rd_o          : one-cycle bus strobes
//   sys_addr_o, sys_wdata_o     : bus address / write data
//   sys_rdata_i                 : read data, valid one cycle after sys_rd_o
module spi_debug_bridge
  import spi_dbg_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 15,
  parameter int INIT_DELAY = 65535
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          spi_clk,
  input  logic          spi_cs_i,
  input  logic          spi_data_i,
  output logic          spi_data_o,
  output logic          sys_wr_o,
  output logic          sys_rd_o,
  output logic [AW-1:0] sys_addr_o,
  output logic [DW-1:0] sys_wdata_o,
  input  logic [DW-1:0] sys_rdata_i
);

  localparam int             BCW  = $clog2(DW);
  localparam int             RB   = cmd_rd_bit(DW);
  localparam logic [BCW-1:0] LAST = BCW'(DW - 1);

  logic w_sclk, w_cs_n, w_mosi;

  sync_2ff u_sync_sclk (.i_clk(sys_clk), .i_rst(sys_rst), .i_d(spi_clk),    .o_q(w_sclk));
  sync_2ff u_sync_cs   (.i_clk(sys_clk), .i_rst(sys_rst), .i_d(spi_cs_i),   .o_q(w_cs_n));
  sync_2ff u_sync_mosi (.i_clk(sys_clk), .i_rst(sys_rst), .i_d(spi_data_i), .o_q(w_mosi));

  state_t          r_state;
  logic            r_sclk_d, r_armed, r_wr, r_inc;
  logic [BCW-1:0]  r_bitcnt;
  logic [DW-2:0]   r_shift;
  logic [31:0]     r_init;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            w_rise, w_done, w_en, w_rd_inc;
  logic [DW-1:0]   w_word;

  assign w_rise = w_sclk & ~r_sclk_d;
  // LSB-first: the bit arriving now is the MSB of the completed word
  assign w_word = {w_mosi, r_shift};
  assign w_done = w_rise && !w_cs_n && (r_state != ST_IDLE) && (r_bitcnt == LAST);
  assign w_en   = (r_init >= 32'(INIT_DELAY));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_sclk_d <= 1'b0;
      r_armed  <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_init   <= '0;
      r_wr     <= 1'b0;
      r_inc    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_sclk_d <= w_sclk;
      r_wr     <= 1'b0;
      r_inc    <= 1'b0;
      if (!w_en) r_init <= r_init + 32'd1;
      // address advances the cycle after a write strobe / read capture
      if (r_inc || w_rd_inc) r_addr <= r_addr + 1'b1;

      if (w_cs_n) begin
        // a frame live at reset release is ignored until cs is seen high
        r_armed  <= 1'b1;
        r_state  <= ST_IDLE;
        r_bitcnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (r_armed) begin
            r_state  <= ST_CMD;
            r_bitcnt <= '0;
          end
          default: if (w_rise) begin
            r_shift  <= w_word[DW-1:1];
            r_bitcnt <= w_done ? '0 : r_bitcnt + 1'b1;
            if (w_done) begin
              case (r_state)
                ST_CMD: begin
                  r_addr  <= w_word[AW-1:0];
                  r_state <= w_word[RB] ? ST_READ : ST_WRITE;
                end
                ST_WRITE: begin
                  r_wdata <= w_word;
                  r_wr    <= w_en;
                  r_inc   <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign sys_wr_o    = r_wr;
  assign sys_addr_o  = r_addr;
  assign sys_wdata_o = r_wdata;

`ifdef SPI_DEBUG_READ_EN
  logic          w_fall, w_rd_start, r_rd, r_rd_d, r_cap;
  logic [DW-1:0] r_oshift;

  assign w_fall     = ~w_sclk & r_sclk_d;
  // fetch on the read command and after every completed read word, so the
  // next word is staged before the master starts clocking it out
  assign w_rd_start = w_done && ((r_state == ST_CMD && w_word[RB]) || r_state == ST_READ);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd     <= 1'b0;
      r_rd_d   <= 1'b0;
      r_cap    <= 1'b0;
      r_oshift <= '0;
    end else begin
      r_rd   <= w_rd_start & w_en;
      r_rd_d <= w_rd_start;
      r_cap  <= r_rd_d;
      if (r_cap)
        r_oshift <= sys_rdata_i;
      else if (r_state != ST_READ)
        r_oshift <= '0;
      // the falling edge closing a word (bitcnt back at 0) must not shift:
      // bit 0 of the freshly loaded word is what the master samples next
      else if (w_fall && r_bitcnt != '0)
        r_oshift <= {1'b0, r_oshift[DW-1:1]};
    end
  end

  assign w_rd_inc   = r_cap;
  assign sys_rd_o   = r_rd;
  assign spi_data_o = (r_state == ST_READ) & r_oshift[0];
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^sys_rdata_i;
  assign w_rd_inc   = 1'b0;
  assign sys_rd_o   = 1'b0;
  assign spi_data_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_debug_bridge.sv
module tb_spi_debug_bridge;
  localparam int DW   = 16;
  localparam int AW   = 15;
  localparam int INIT = 2000;
  localparam int H    = 8;   // SPI half period in sys_clk cycles

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_cs_i = 1'b1;
  logic          spi_data_i = 1'b0;
  logic          spi_data_o, sys_wr_o, sys_rd_o;
  logic [AW-1:0] sys_addr_o;
  logic [DW-1:0] sys_wdata_o;
  logic [DW-1:0] sys_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int miso_hi = 0;
  int rd_exp = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_miso[$];
  wr_t           mon_e;
  int            mcnt = 0;
  logic [DW-1:0] mword = '0;

  always #5 sys_clk = ~sys_clk;

  spi_debug_bridge #(.DW(DW), .AW(AW), .INIT_DELAY(INIT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .spi_clk    (spi_clk),
    .spi_cs_i   (spi_cs_i),
    .spi_data_i (spi_data_i),
    .spi_data_o (spi_data_o),
    .sys_wr_o   (sys_wr_o),
    .sys_rd_o   (sys_rd_o),
    .sys_addr_o (sys_addr_o),
    .sys_wdata_o(sys_wdata_o),
    .sys_rdata_i(sys_rdata_i)
  );

  // bus slave: read data is addr ^ 0xA5A5, one cycle after the strobe
  always @(posedge sys_clk)
    sys_rdata_i <= sys_rd_o ? (DW'(sys_addr_o) ^ 16'hA5A5) : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  // mode-0 master: MOSI changes with the falling edge, LSB first
  task automatic frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input logic [DW-1:0] w2, input int nw, input int lastbits);
    logic [DW-1:0] w [3];
    int nb;
    w[0] = w0; w[1] = w1; w[2] = w2;
    spi_cs_i = 1'b0;
    cyc(H);
    for (int i = 0; i < nw; i++) begin
      nb = (i == nw - 1) ? lastbits : DW;
      for (int b = 0; b < nb; b++) begin
        spi_data_i = w[i][b];
        cyc(H);
        spi_clk = 1'b1;
        cyc(H);
        spi_clk = 1'b0;
      end
    end
    cyc(H);
    spi_cs_i = 1'b1;
    cyc(4 * H);
  endtask

  // strobe monitor
  always @(negedge sys_clk) begin
    if (sys_rd_o) rd_cnt++;
    if (spi_data_o) miso_hi++;
    if (sys_wr_o && sys_rd_o) begin
      checks++; errors++;
      $display("FAIL wr_rd_overlap: both strobes high at addr %0h", sys_addr_o);
    end
    if (sys_wr_o) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h, expected no strobe", sys_addr_o, sys_wdata_o);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", 32'(sys_addr_o), 32'(mon_e.addr));
        chk("wr_data", 32'(sys_wdata_o), 32'(mon_e.data));
      end
    end
  end

  // MISO monitor: master samples on rising spi_clk
  always @(posedge spi_clk or posedge spi_cs_i) begin
    if (spi_cs_i) mcnt = 0;
    else begin
      mword = {spi_data_o, mword[DW-1:1]};
      mcnt++;
      if (mcnt == DW) begin
        mcnt = 0;
        if (exp_miso.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_miso_word: got %0h, expected none", mword);
        end else chk("miso_word", 32'(mword), 32'(exp_miso.pop_front()));
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr"},    32'(sys_wr_o),    0);
    chk({tag, "_rd"},    32'(sys_rd_o),    0);
    chk({tag, "_addr"},  32'(sys_addr_o),  0);
    chk({tag, "_wdata"}, 32'(sys_wdata_o), 0);
    chk({tag, "_miso"},  32'(spi_data_o),  0);
  endtask

  initial begin
    sys_rst = 1'b1;
    cyc(5);
    chk_zero_outputs("reset");
    sys_rst = 1'b0;

    // holdoff: frame completes well before INIT cycles -> no strobe
    exp_miso.push_back('0); exp_miso.push_back('0);
    frame(16'h0005, 16'h1111, '0, 2, DW);
    cyc(INIT);

    // basic write
    push_wr(15'h0010, 16'hBEEF); push_wr(15'h0011, 16'h1234);
    repeat (3) exp_miso.push_back('0);
    frame(16'h0010, 16'hBEEF, 16'h1234, 3, DW);
    chk("addr_after_write", 32'(sys_addr_o), 32'h12);

    // address wrap
    push_wr(15'h7FFF, 16'hAAAA); push_wr(15'h0000, 16'h5555);
    repeat (3) exp_miso.push_back('0);
    frame(16'h7FFF, 16'hAAAA, 16'h5555, 3, DW);
    chk("addr_after_wrap", 32'(sys_addr_o), 32'h1);

    // abort after 9 bits of a data word
    exp_miso.push_back('0);
    frame(16'h0040, 16'hFFFF, '0, 2, 9);
    chk("addr_after_abort", 32'(sys_addr_o), 32'h40);

    push_wr(15'h0050, 16'h4444);
    exp_miso.push_back('0); exp_miso.push_back('0);
    frame(16'h0050, 16'h4444, '0, 2, DW);
    chk("addr_after_clean", 32'(sys_addr_o), 32'h51);

    // read frame
    exp_miso.push_back('0);
`ifdef SPI_DEBUG_READ_EN
    exp_miso.push_back(16'hA585); exp_miso.push_back(16'hA584);
    rd_exp = 3;
`else
    exp_miso.push_back('0); exp_miso.push_back('0);
    rd_exp = 0;
`endif
    frame(16'h8020, '0, '0, 3, DW);

    push_wr(15'h0030, 16'hABCD);
    exp_miso.push_back('0); exp_miso.push_back('0);
    frame(16'h0030, 16'hABCD, '0, 2, DW);

    // reset in the middle of the data word of a write frame
    exp_miso.push_back('0); exp_miso.push_back('0);
    fork
      frame(16'h0060, 16'h6666, '0, 2, DW);
      begin
        cyc(H + DW * 2 * H + 5 * 2 * H);
        sys_rst = 1'b1;
        cyc(1);
        chk_zero_outputs("midreset");
        sys_rst = 1'b0;
      end
    join

    cyc(INIT + 100);
    push_wr(15'h0070, 16'h7777);
    exp_miso.push_back('0); exp_miso.push_back('0);
    frame(16'h0070, 16'h7777, '0, 2, DW);
    cyc(20);

    chk("wr_queue_drained",   32'(exp_wr.size()),   0);
    chk("miso_queue_drained", 32'(exp_miso.size()), 0);
    chk("rd_pulse_count",     32'(rd_cnt),          32'(rd_exp));
`ifndef SPI_DEBUG_READ_EN
    chk("miso_high_cycles",   32'(miso_hi),         0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, expected completion within 2ms");
    $fatal(1);
  end

endmodule

// File: doc/spi_debug_bridge.md
SPI_DEBUG_BRIDGE -- requirements
Module: spi_debug_bridge

Interface
REQ-001 SHALL have parameter DW, default 16: data word width in bits; legal range 8..32.
REQ-002 SHALL have parameter AW, default 15: address width; AW <= DW-1.
REQ-003 SHALL have parameter INIT_DELAY, default 65535: sys_clk cycles after reset before bus access is enabled.
REQ-004 SHALL have port sys_clk, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port spi_clk, input, 1: SPI mode-0 serial clock, asynchronous, sampled by sys_clk.
REQ-007 SHALL have port spi_cs_i, input, 1: chip select, active-low, asynchronous.
REQ-008 SHALL have port spi_data_i, input, 1: MOSI, asynchronous.
REQ-009 SHALL have port spi_data_o, output, 1: MISO.
REQ-010 SHALL have port sys_wr_o, output, 1: one-cycle write strobe.
REQ-011 SHALL have port sys_rd_o, output, 1: one-cycle read strobe.
REQ-012 SHALL have port sys_addr_o, output, AW: bus address.
REQ-013 SHALL have port sys_wdata_o, output, DW: write data.
REQ-014 SHALL have port sys_rdata_i, input, DW: read data, valid exactly one cycle after sys_rd_o.

Function
REQ-015 SHALL pass spi_clk, spi_cs_i and spi_data_i each through a two-flop synchronizer; the design operates correctly only when sys_clk >= 8x spi_clk.
REQ-016 SHALL sample MOSI on each synchronized spi_clk rising edge and shift words LSB-first; DW edges form one word.
REQ-017 SHALL implement FSM IDLE -> CMD on cs low; CMD -> WRITE or READ after the first word; any state -> IDLE on cs high.
REQ-018 SHALL treat the first word of a frame as the command: bit DW-1 = 1 for read, 0 for write; bits AW-1:0 = start address; remaining bits ignored.
REQ-019 In WRITE, SHALL, for each completed word, load sys_wdata_o, drive sys_wr_o high for one cycle, then increment sys_addr_o on the following cycle.
REQ-020 On entering READ and after each completed read word, SHALL pulse sys_rd_o for one cycle at sys_addr_o, capture sys_rdata_i on the next cycle into the output shifter, then increment the address.
REQ-021 SHALL drive spi_data_o from the output shifter LSB first, advancing one bit per synchronized spi_clk falling edge; word k of a read frame returns mem[start+k].
REQ-022 SHALL drive spi_data_o 0 in IDLE, CMD and WRITE.
REQ-023 Address increment SHALL wrap from 2^AW-1 to 0.
REQ-024 If cs rises mid-word, SHALL discard the partial word with no strobe and keep the address unchanged.
REQ-025 SHALL never assert sys_wr_o and sys_rd_o in the same cycle.
REQ-026 While the startup counter is below INIT_DELAY, SHALL suppress both strobes; completed words still advance the FSM and the address.

Reset
REQ-027 On sys_rst, SHALL clear all outputs to 0 and set the FSM to IDLE, the bit counter to 0 and the startup counter to 0.
REQ-028 After reset, SHALL ignore the bus until cs is seen high; a frame already in progress when reset is released is discarded.

Configuration
REQ-029 With SPI_DEBUG_READ_EN defined, SHALL implement READ as specified.
REQ-030 Without SPI_DEBUG_READ_EN, SHALL treat read commands as a sink: data words discarded, sys_rd_o tied 0, spi_data_o tied 0, and no output shifter synthesized.

Structure
REQ-031 SHALL place the FSM state encoding and the command read-bit position (DW-1) in shared package spi_dbg_pkg.
REQ-032 SHALL instantiate sub-module sync_2ff, one per asynchronous input.

Verification
REQ-033 Write: reset, wait INIT_DELAY, frame {0x0010, 0xBEEF, 0x1234} -> wr pulses at addr 0x0010 (data 0xBEEF) and 0x0011 (data 0x1234), exactly two pulses.
REQ-034 Read (READ_EN): model returns addr^0xA5A5; frame {0x8020, dummy, dummy} -> MISO words 0xA585, 0xA584.
REQ-035 Wrap: write frame at 0x7FFF with two data words -> strobes at 0x7FFF then 0x0000.
REQ-036 Abort: cs high after 9 bits of a data word -> no sys_wr_o; next frame starts clean.
REQ-037 Holdoff: frame sent before INIT_DELAY expires -> zero strobes; with reset asserted mid-frame, all outputs 0 next cycle and no strobes until the next cs low.
REQ-038 Without READ_EN: read frame -> sys_rd_o and spi_data_o stay 0 throughout.
